// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - bin, LSB first, one full-subtractor cell plus a borrow flop
// Ports: clock/resetn (async active-low); start/A/B/bin request and operands captured on the accepting edge;
// busy high during RUN; done one-cycle result pulse; D/bout/ovf result, held until the next completion.
// Define SERIAL_SUB_OVF_EN to produce the signed-overflow flag on ovf; otherwise ovf is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             br, d, br_nx, last;
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res_nx = {d, res[WIDTH-1:1]};
  assign last   = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_nx;
      res <= res_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= FIN;
        busy  <= 1'b0;
        done  <= 1'b1;
        D     <= res_nx;
        bout  <= br_nx;
      end
    end else if (start) begin
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
      sa    <= A;
      sb    <= B;
      br    <= bin;
      res   <= '0;
      cnt   <= '0;
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits are shifted out of sa/sb, so keep copies for the overflow test
  logic am, bm;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      am  <= 1'b0;
      bm  <= 1'b0;
      ovf <= 1'b0;
    end else if (state == RUN) begin
      if (last) ovf <= (am != bm) & (res_nx[WIDTH-1] != am);
    end else if (start) begin
      am <= A[WIDTH-1];
      bm <= B[WIDTH-1];
    end
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;
  logic       clock = 1'b0;
  logic       resetn, start, bin;
  logic [3:0] A, B;
  logic       busy, done, bout, ovf;
  logic [3:0] D;
  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .A(A), .B(B), .bin(bin),
    .busy(busy), .done(done), .D(D), .bout(bout), .ovf(ovf)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
`ifdef SERIAL_SUB_OVF_EN
    return (a[3] != b[3]) && (d[3] != a[3]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ed, input logic eb, input logic eo);
    A = a; B = b; bin = bi; start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      step;
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("D", D, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    step;
    chk("done_clear", done, 1'b0);
  endtask

  initial begin
    logic [4:0] full;
    resetn = 1'b0; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    step;
    step;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_D", D, 4'h0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    resetn = 1'b1;
    step;
    do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0);
    do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, exp_ovf(4'd3, 4'd9, 4'hA));
    do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    // start held during RUN with new operands must be ignored
    A = 4'd9; B = 4'd3; bin = 1'b0; start = 1'b1;
    step;
    A = 4'd15; B = 4'd15;
    step;
    step;
    step;
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    step;
    chk("ign_done", done, 1'b1);
    chk("ign_D", D, 4'd6);
    chk("ign_bout", bout, 1'b0);
    step;
    chk("ign_idle_busy", busy, 1'b0);
    chk("ign_idle_done", done, 1'b0);
    // reset during RUN aborts without a done pulse
    A = 4'd9; B = 4'd3; bin = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_D", D, 4'h0);
    chk("abort_bout", bout, 1'b0);
    step;
    step;
    chk("abort_nodone", done, 1'b0);
    resetn = 1'b1;
    step;
    chk("abort_idle_done", done, 1'b0);
    do_op(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    // back-to-back: start during the done cycle
    A = 4'd9; B = 4'd3; bin = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    step;
    step;
    chk("b2b_done1", done, 1'b1);
    chk("b2b_D1", D, 4'd6);
    A = 4'd7; B = 4'd2; start = 1'b1;
    step;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done_low", done, 1'b0);
    chk("b2b_D_hold", D, 4'd6);
    step;
    step;
    step;
    chk("b2b_busy_last", busy, 1'b1);
    step;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_D2", D, 4'd5);
    chk("b2b_bout2", bout, 1'b0);
    step;
`ifdef SERIAL_SUB_OVF_EN
    do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
`else
    do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
`endif
    do_op(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a, b;
      logic bi;
      a = 4'(i >> 5);
      b = 4'(i >> 1);
      bi = i[0];
      full = {1'b0, a} - {1'b0, b} - {4'b0, bi};
      do_op(a, b, bi, full[3:0], full[4], exp_ovf(a, b, full[3:0]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
